mysystem_pio_pulse_seq: RTL and testbench

- Avalon-MM slave pulse-train sequencer that drives a single-bit output pin. It sits in mysystem next to the plain PIO output ports.
- Software programs the high time, low time and pulse count, then writes start. The block generates the waveform autonomously, so the CPU does not have to bit-bang a PIO register.
- Status and a completed-pulse counter can be read back over the same slave.

---
 rtl/mysystem_pio_pulse_seq_if.sv | 29 ++
 rtl/mysystem_pio_pulse_seq.sv | 175 +++++++++++++++++
 tb/tb_mysystem_pio_pulse_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mysystem_pio_pulse_seq_if.sv
// Avalon-MM slave bus bundle for mysystem_pio_pulse_seq.
//   address    : register word select (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, combinational from address
interface mysystem_pio_pulse_seq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/mysystem_pio_pulse_seq.sv
// Pulse-train sequencer behind an Avalon-MM slave. Software programs the
// high time, low time and pulse count, then writes START; the block drives
// out_port autonomously and counts completed pulses.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port : generated pulse train (phase_high XOR POL)
//   busy     : high while the sequencer is not idle
// Register map: 0 CTRL (START/STOP self-clearing, POL bit2), 1 HIGH_CNT,
// 2 LOW_CNT, 3 REPEAT (0 = endless), 4 STATUS {DONE, busy}, 5 PULSES.
module mysystem_pio_pulse_seq #(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    mysystem_pio_pulse_seq_if.slave     bus,
    output logic                        out_port,
    output logic                        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   tcnt_reg, tcnt_next;
    logic [CNT_W-1:0]   pulses_reg, pulses_next;
    logic               done_reg, done_next;

    logic               pol_reg;
    logic [CNT_W-1:0]   high_cnt_reg;
    logic [CNT_W-1:0]   low_cnt_reg;
    logic [CNT_W-1:0]   repeat_reg;

    logic               wr;
    logic               ctrl_wr;
    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   high_load;
    logic [CNT_W-1:0]   low_load;
    logic [CNT_W-1:0]   pulses_inc;
    logic               unused_wdata;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign ctrl_wr = wr && (bus.address == 3'd0);
    assign start   = ctrl_wr & bus.writedata[0];
    assign stop    = ctrl_wr & bus.writedata[1];

    // A programmed count of 0 behaves as 1 cycle; tcnt counts down to 0.
    assign high_load  = (high_cnt_reg == '0) ? '0 : high_cnt_reg - ONE;
    assign low_load   = (low_cnt_reg  == '0) ? '0 : low_cnt_reg  - ONE;
    assign pulses_inc = pulses_reg + ONE;

    // Upper write-data bits have no destination.
    assign unused_wdata = ^bus.writedata;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pol_reg      <= 1'b0;
            high_cnt_reg <= '0;
            low_cnt_reg  <= '0;
            repeat_reg   <= '0;
        end else if (wr) begin
            case (bus.address)
                3'd0:    pol_reg      <= bus.writedata[2];
                3'd1:    high_cnt_reg <= bus.writedata[CNT_W-1:0];
                3'd2:    low_cnt_reg  <= bus.writedata[CNT_W-1:0];
                3'd3:    repeat_reg   <= bus.writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            tcnt_reg   <= '0;
            pulses_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tcnt_reg   <= tcnt_next;
            pulses_reg <= pulses_next;
            done_reg   <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        tcnt_next   = tcnt_reg;
        pulses_next = pulses_reg;
        done_next   = done_reg;

        case (state_reg)
            IDLE: begin
                // STOP in the same write as START keeps the block idle.
                if (start && !stop) begin
                    state_next  = HIGH;
                    tcnt_next   = high_load;
                    pulses_next = '0;
                    done_next   = 1'b0;
                end
            end

            HIGH: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (tcnt_reg == '0) begin
                    state_next = LOW;
                    tcnt_next  = low_load;
                end else begin
                    tcnt_next = tcnt_reg - ONE;
                end
            end

            LOW: begin
                if (tcnt_reg == '0) begin
                    // The completed pulse is counted even if STOP lands now.
                    pulses_next = pulses_inc;
                    if (stop) begin
                        state_next = IDLE;
                    end else if ((repeat_reg != '0) && (pulses_inc == repeat_reg)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = HIGH;
                        tcnt_next  = high_load;
                    end
                end else if (stop) begin
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt_reg - ONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (state_reg != IDLE);
    assign out_port = (state_reg == HIGH) ^ pol_reg;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata[2]         = pol_reg;
            3'd1:    bus.readdata[CNT_W-1:0] = high_cnt_reg;
            3'd2:    bus.readdata[CNT_W-1:0] = low_cnt_reg;
            3'd3:    bus.readdata[CNT_W-1:0] = repeat_reg;
            3'd4:    bus.readdata[1:0]       = {done_reg, busy};
            3'd5:    bus.readdata[CNT_W-1:0] = pulses_reg;
            default: bus.readdata            = '0;
        endcase
    end

endmodule

// File: tb/tb_mysystem_pio_pulse_seq.sv
// Directed testbench for mysystem_pio_pulse_seq.
module tb_mysystem_pio_pulse_seq;

    logic clk;
    logic reset_n;
    logic out_port;
    logic busy;

    int n_assert = 0;
    int n_fail   = 0;

    mysystem_pio_pulse_seq_if bus ();

    mysystem_pio_pulse_seq #(.CNT_W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One write, registered on the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        $display("write addr=%0d data=0x%0h", addr, data);
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        $display("read  addr=%0d data=0x%0h", addr, bus.readdata);
        check(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    initial begin
        logic [9:0] pat1;
        pat1 = 10'b1110011100;

        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_out", {31'd0, out_port}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) read_check("rst_read", 3'(a), 32'd0);

        // ---------------- HIGH=3 LOW=2 REPEAT=2 ----------------
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'd2);
        bus_write(3'd3, 32'd2);
        bus_write(3'd0, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t1_pattern", {31'd0, out_port}, {31'd0, pat1[9-i]});
        end
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_out_idle", {31'd0, out_port}, 32'd0);
        read_check("t1_status", 3'd4, 32'h2);
        read_check("t1_pulses", 3'd5, 32'd2);
        read_check("t1_high", 3'd1, 32'd3);
        read_check("t1_low", 3'd2, 32'd2);
        read_check("t1_repeat", 3'd3, 32'd2);
        read_check("t1_ctrl", 3'd0, 32'd0);

        // ---------------- HIGH=0 LOW=0 REPEAT=4 ----------------
        bus_write(3'd1, 32'd0);
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'd4);
        bus_write(3'd0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_pattern", {31'd0, out_port}, {31'd0, (i % 2) == 0});
        end
        @(negedge clk);
        check("t2_busy", {31'd0, busy}, 32'd0);
        read_check("t2_status", 3'd4, 32'h2);
        read_check("t2_pulses", 3'd5, 32'd4);

        // ---------------- endless train, STOP on a pulse completion ----------------
        bus_write(3'd3, 32'd0);
        bus_write(3'd1, 32'd2);
        bus_write(3'd2, 32'd2);
        bus_write(3'd0, 32'd1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("t3_pattern", {31'd0, out_port}, {31'd0, ((i - 1) % 4) < 2});
        end
        bus_write(3'd0, 32'd2);
        @(negedge clk);
        check("t3_out_stop", {31'd0, out_port}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        read_check("t3_status", 3'd4, 32'h0);
        read_check("t3_pulses", 3'd5, 32'd5);

        // ---------------- POL and START-while-busy ----------------
        bus_write(3'd0, 32'd4);
        @(negedge clk);
        check("t4_pol_idle", {31'd0, out_port}, 32'd1);
        bus_write(3'd1, 32'd1);
        bus_write(3'd2, 32'd1);
        bus_write(3'd3, 32'd1);
        bus_write(3'd0, 32'd5);
        check("t4_high_inv", {31'd0, out_port}, 32'd0);
        bus_write(3'd0, 32'd5);
        check("t4_low_inv", {31'd0, out_port}, 32'd1);
        check("t4_busy_run", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("t4_out_end", {31'd0, out_port}, 32'd1);
        check("t4_busy_end", {31'd0, busy}, 32'd0);
        read_check("t4_pulses", 3'd5, 32'd1);
        read_check("t4_status", 3'd4, 32'h2);
        read_check("t4_ctrl", 3'd0, 32'h4);

        // ---------------- asynchronous reset mid-train ----------------
        bus_write(3'd1, 32'd5);
        bus_write(3'd3, 32'd3);
        bus_write(3'd0, 32'd1);
        @(negedge clk);
        check("t5_out_high", {31'd0, out_port}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_rst_out", {31'd0, out_port}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 8; a++) read_check("t5_rst_read", 3'(a), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_write(3'd0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_toggle", {31'd0, out_port}, {31'd0, (i % 2) == 0});
        end
        read_check("t5_pulses", 3'd5, 32'd3);
        read_check("t5_status", 3'd4, 32'h1);
        bus_write(3'd0, 32'd2);
        @(negedge clk);
        check("t5_stop_busy", {31'd0, busy}, 32'd0);
        check("t5_stop_out", {31'd0, out_port}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
